nibble_serial_addsub: RTL and testbench

Multi-cycle add/subtract sequencer that feeds a single 4-bit ripple-carry adder (`rca`) one nibble per cycle. Each `NIBBLES*4`-bit operation is carried across cycles through a registered carry. The block sits directly upstream of the `rca` datapath and consumes its `sum`/`c_out`. It exposes valid/ready handshakes on both sides, so wide add/subtract operations can be built from the existing 4-bit adder.

---
 rtl/nibble_serial_addsub.sv | 124 ++++++++++++
 tb/tb_nibble_serial_addsub.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub.sv
// Wide add/subtract built from one 4-bit ripple-carry adder, one nibble per cycle.
// Carry is registered between nibbles; valid/ready handshakes on both sides.

module rca (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] c;

    always_comb begin
        c[0] = c_in;
        sum  = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        c_out = c[4];
    end
endmodule

module nibble_serial_addsub #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 c_out,
    output logic                 ovf
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [IdxW-1:0] idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q, b_q, acc_q;
    logic [W-1:0]    result_q;
    logic            c_out_q, ovf_q;

    logic [3:0]      nib_a, nib_b, nib_sum;
    logic            nib_c_out;
    logic [W-1:0]    full_sum;

    always_comb begin
        nib_a = a_q[4*idx_q +: 4];
        nib_b = b_q[4*idx_q +: 4];
    end

    rca u_rca (
        .x     (nib_a),
        .y     (nib_b),
        .c_in  (carry_q),
        .sum   (nib_sum),
        .c_out (nib_c_out)
    );

    // Accumulator with the current nibble merged in; on the last nibble this is the result.
    always_comb begin
        full_sum = acc_q;
        full_sum[4*idx_q +: 4] = nib_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {W{sub}};
                        carry_q <= sub;
                        idx_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q   <= full_sum;
                    carry_q <= nib_c_out;
                    if (idx_q == LastIdx) begin
                        result_q <= full_sum;
                        c_out_q  <= nib_c_out;
                        ovf_q    <= (a_q[W-1] == b_q[W-1]) && (nib_sum[3] != a_q[W-1]);
                        idx_q    <= '0;
                        state_q  <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed and random ops on a 4-nibble and a 1-nibble instance,
// checked against an integer-arithmetic reference model.

module tb_nibble_serial_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready, c_out, ovf;
    logic [15:0] a, b, result;

    logic        n1_in_valid, n1_in_ready, n1_sub, n1_out_valid, n1_out_ready, n1_c_out, n1_ovf;
    logic [3:0]  n1_a, n1_b, n1_result;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub #(.NIBBLES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    nibble_serial_addsub #(.NIBBLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (n1_in_valid),
        .in_ready  (n1_in_ready),
        .a         (n1_a),
        .b         (n1_b),
        .sub       (n1_sub),
        .out_valid (n1_out_valid),
        .out_ready (n1_out_ready),
        .result    (n1_result),
        .c_out     (n1_c_out),
        .ovf       (n1_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, c_out, result[15:0]} for a w-bit add/subtract.
    function automatic logic [17:0] ref_op(input int unsigned x, input int unsigned y,
                                           input bit s, input int w);
        int unsigned mask, res;
        int          sx, sy, sr;
        bit          c, ov;
        mask = (32'd1 << w) - 1;
        res  = s ? ((x - y) & mask) : ((x + y) & mask);
        c    = s ? (x >= y) : ((x + y) > mask);
        sx   = (x >= (32'd1 << (w - 1))) ? int'(x) - (1 << w) : int'(x);
        sy   = (y >= (32'd1 << (w - 1))) ? int'(y) - (1 << w) : int'(y);
        sr   = s ? sx - sy : sx + sy;
        ov   = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
        return {ov, c, res[15:0]};
    endfunction

    task automatic op4(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                       input int stall, input string tag);
        logic [17:0] e;
        int          cnt;
        e = ref_op(ta, tb_, ts, 16);
        chk({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1; a = ta; b = tb_; sub = ts;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, " latency"}, cnt, 4);
        chk({tag, " result"}, result, e[15:0]);
        chk({tag, " c_out"}, c_out, e[16]);
        chk({tag, " ovf"}, ovf, e[17]);
        repeat (stall) begin
            @(posedge clk); #1;
            chk({tag, " held"}, out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, out_valid, 0);
        chk({tag, " in_ready back"}, in_ready, 1);
    endtask

    initial begin
        logic [15:0] held_res;
        logic [17:0] e1;
        int          cnt;

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a = 16'h5555; b = 16'h1111; sub = 1'b0;
        n1_in_valid = 1'b0; n1_out_ready = 1'b0; n1_a = '0; n1_b = '0; n1_sub = 1'b0;

        // Reset held two cycles with in_valid asserted
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst out_valid", out_valid, 0);
            chk("rst result", result, 0);
            chk("rst c_out", c_out, 0);
            chk("rst ovf", ovf, 0);
            chk("rst in_ready", in_ready, 0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1 chk("post-rst in_ready", in_ready, 1);

        // Directed add/sub
        op4(16'h1234, 16'h0FFF, 1'b0, 0, "add1");
        op4(16'hFFFF, 16'h0001, 1'b0, 0, "add2");
        op4(16'h7FFF, 16'h0001, 1'b0, 1, "add3");
        op4(16'h0005, 16'h0007, 1'b1, 0, "sub1");
        op4(16'h8000, 16'h0001, 1'b1, 0, "sub2");
        op4(16'h1234, 16'h1234, 1'b1, 2, "sub3");

        // Back-pressure with an ignored request during DONE
        in_valid = 1'b1; a = 16'h4321; b = 16'h1111; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("bp latency", cnt, 4);
        chk("bp result", result, 16'h5432);
        held_res = result;
        in_valid = 1'b1; a = 16'hAAAA;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp out_valid", out_valid, 1);
            chk("bp result stable", result, held_res);
            chk("bp in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp drop", out_valid, 0);
        chk("bp in_ready", in_ready, 1);
        repeat (6) begin
            @(posedge clk); #1;
            chk("bp no capture", out_valid, 0);
        end

        // Reset after two RUN cycles aborts the op
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst result", result, 0);
        chk("midrst c_out", c_out, 0);
        chk("midrst ovf", ovf, 0);
        repeat (6) begin
            chk("midrst out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        op4(16'h00FF, 16'h0001, 1'b0, 0, "after rst");

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            op4(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand");
        end

        // Single-nibble instance
        e1 = ref_op(9, 8, 1'b0, 4);
        chk("n1 in_ready", n1_in_ready, 1);
        n1_in_valid = 1'b1; n1_a = 4'h9; n1_b = 4'h8;
        @(posedge clk); #1;
        n1_in_valid = 1'b0;
        chk("n1 run", n1_out_valid, 0);
        @(posedge clk); #1;
        chk("n1 out_valid", n1_out_valid, 1);
        chk("n1 result", n1_result, e1[3:0]);
        chk("n1 c_out", n1_c_out, e1[16]);
        chk("n1 ovf", n1_ovf, e1[17]);
        n1_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("n1 in_ready back", n1_in_ready, 1);

        // Back-to-back: accepts every third cycle
        n1_in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("n1 b2b in_ready", n1_in_ready, (k % 3) == 0);
            chk("n1 b2b out_valid", n1_out_valid, (k % 3) == 2);
            n1_a = 4'($urandom); n1_b = 4'($urandom); n1_sub = 1'($urandom);
            if (k % 3 == 0) e1 = ref_op(n1_a, n1_b, n1_sub, 4);
            if (k % 3 == 2) chk("n1 b2b result", n1_result, e1[3:0]);
            @(posedge clk); #1;
        end
        n1_in_valid = 1'b0; n1_out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
